// File: rtl/rx_block_sync_ctrl.sv
// 64b/66b receive block-sync controller: hunts for sync-header alignment, drives gearbox slips,
// reports block lock. Optional hi-BER monitor is built only when RX_HI_BER_MONITOR_EN is defined.
module rx_block_sync_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int BAD_LIMIT = 16,
  parameter int SLIP_WAIT = 32,
  parameter int BER_WIN   = 19531
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [65:0] data_i,
  input  logic        data_vld_i,
  output logic [65:0] data_o,
  output logic        data_vld_o,
  output logic        slip_o,
  output logic        block_lock_o,
  output logic        hi_ber_o
);

  localparam int              SLIP_W    = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [6:0]      LOCK_C    = 7'(LOCK_CNT);
  localparam logic [4:0]      BAD_C     = 5'(BAD_LIMIT);
  localparam logic [6:0]      WIN_C     = 7'd64;
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  // Counter widths are fixed, so out-of-range parameters are rejected at elaboration.
  if (LOCK_CNT < 1 || LOCK_CNT > 127 || BAD_LIMIT < 1 || BAD_LIMIT > 31 ||
      SLIP_WAIT < 1 || BER_WIN < 2) begin : g_bad_param
    $error("rx_block_sync_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {ST_HUNT, ST_SLIP, ST_LOCKED} state_t;

  state_t              r_state, w_state_next;
  logic [6:0]          r_sh_cnt, w_sh_cnt_next, w_sh_inc;
  logic [4:0]          r_bad_cnt, w_bad_cnt_next, w_bad_inc;
  logic [SLIP_W-1:0]   r_slip_cnt, w_slip_cnt_next;
  logic                w_slip_next;
  logic                w_hdr_ok, w_hdr_bad;
  logic [65:0]         r_data;
  logic                r_data_vld, r_slip, r_lock;

  assign w_hdr_ok  = data_vld_i && (data_i[1:0] == 2'b01 || data_i[1:0] == 2'b10);
  assign w_hdr_bad = data_vld_i && !(data_i[1:0] == 2'b01 || data_i[1:0] == 2'b10);
  assign w_sh_inc  = (r_sh_cnt == 7'h7f) ? r_sh_cnt : r_sh_cnt + 7'd1;
  assign w_bad_inc = (w_hdr_bad && r_bad_cnt != 5'h1f) ? r_bad_cnt + 5'd1 : r_bad_cnt;

  always_comb begin
    w_state_next    = r_state;
    w_sh_cnt_next   = r_sh_cnt;
    w_bad_cnt_next  = r_bad_cnt;
    w_slip_cnt_next = r_slip_cnt;
    w_slip_next     = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_hdr_ok) begin
          if (w_sh_inc >= LOCK_C) begin
            w_state_next   = ST_LOCKED;
            w_sh_cnt_next  = 7'd0;
            w_bad_cnt_next = 5'd0;
          end else begin
            w_sh_cnt_next = w_sh_inc;
          end
        end else if (w_hdr_bad) begin
          w_state_next    = ST_SLIP;
          w_sh_cnt_next   = 7'd0;
          w_bad_cnt_next  = 5'd0;
          w_slip_cnt_next = '0;
          w_slip_next     = 1'b1;
        end
      end
      ST_SLIP: begin
        // Gearbox needs time to settle after the shift; headers seen here are meaningless.
        w_sh_cnt_next  = 7'd0;
        w_bad_cnt_next = 5'd0;
        if (r_slip_cnt >= SLIP_LAST) begin
          w_state_next    = ST_HUNT;
          w_slip_cnt_next = '0;
        end else begin
          w_slip_cnt_next = r_slip_cnt + SLIP_W'(1);
        end
      end
      ST_LOCKED: begin
        if (data_vld_i) begin
          if (w_bad_inc >= BAD_C) begin
            w_state_next    = ST_SLIP;
            w_sh_cnt_next   = 7'd0;
            w_bad_cnt_next  = 5'd0;
            w_slip_cnt_next = '0;
            w_slip_next     = 1'b1;
          end else if (w_sh_inc >= WIN_C) begin
            w_sh_cnt_next  = 7'd0;
            w_bad_cnt_next = 5'd0;
          end else begin
            w_sh_cnt_next  = w_sh_inc;
            w_bad_cnt_next = w_bad_inc;
          end
        end
      end
      default: begin
        w_state_next = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_HUNT;
      r_sh_cnt   <= 7'd0;
      r_bad_cnt  <= 5'd0;
      r_slip_cnt <= '0;
      r_data     <= 66'd0;
      r_data_vld <= 1'b0;
      r_slip     <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sh_cnt   <= w_sh_cnt_next;
      r_bad_cnt  <= w_bad_cnt_next;
      r_slip_cnt <= w_slip_cnt_next;
      if (data_vld_i) r_data <= data_i;
      // Gate on the state the block arrived in, so the unlocking block still goes through.
      r_data_vld <= data_vld_i && (r_state == ST_LOCKED);
      r_slip     <= w_slip_next;
      r_lock     <= (w_state_next == ST_LOCKED);
    end
  end

  assign data_o       = r_data;
  assign data_vld_o   = r_data_vld;
  assign slip_o       = r_slip;
  assign block_lock_o = r_lock;

`ifdef RX_HI_BER_MONITOR_EN
  localparam int             BER_W    = $clog2(BER_WIN);
  localparam logic [BER_W-1:0] BER_LAST = BER_W'(BER_WIN - 1);

  logic [BER_W-1:0] r_ber_win;
  logic [4:0]       r_ber_cnt, w_ber_cnt_inc;
  logic             r_hi_ber;

  // Saturate at 16: once the threshold is hit the exact count no longer matters.
  assign w_ber_cnt_inc = (w_hdr_bad && r_ber_cnt != 5'd16) ? r_ber_cnt + 5'd1 : r_ber_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ber_win <= '0;
      r_ber_cnt <= 5'd0;
      r_hi_ber  <= 1'b0;
    end else begin
      if (w_ber_cnt_inc >= 5'd16) r_hi_ber <= 1'b1;
      else if (r_ber_win == BER_LAST) r_hi_ber <= 1'b0;
      if (r_ber_win == BER_LAST) begin
        r_ber_win <= '0;
        r_ber_cnt <= 5'd0;
      end else begin
        r_ber_win <= r_ber_win + BER_W'(1);
        r_ber_cnt <= w_ber_cnt_inc;
      end
    end
  end

  assign hi_ber_o = r_hi_ber;
`else
  assign hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_block_sync_ctrl.sv
// Bench for rx_block_sync_ctrl: directed scenarios with literal checks plus randomized traffic
// compared every cycle against a behavioural model of the lock/slip/BER rules.
module tb_rx_block_sync_ctrl;
  localparam int LOCK_CNT  = 64;
  localparam int BAD_LIMIT = 16;
  localparam int SLIP_WAIT = 32;
  localparam int BER_WIN   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [65:0] din = 66'd0;
  logic        vld = 1'b0;
  logic [65:0] dout;
  logic        dvld, slip, lock, hiber;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  rx_block_sync_ctrl #(
    .LOCK_CNT(LOCK_CNT), .BAD_LIMIT(BAD_LIMIT), .SLIP_WAIT(SLIP_WAIT), .BER_WIN(BER_WIN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_vld_i(vld),
    .data_o(dout), .data_vld_o(dvld), .slip_o(slip), .block_lock_o(lock), .hi_ber_o(hiber)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode as a small integer, header tallies as plain ints.
  localparam int M_HUNT = 0, M_SLIP = 1, M_LOCK = 2;
  int          m_mode = M_HUNT;
  int          m_good = 0, m_bad = 0, m_slip_left = 0;
  int          m_win_pos = 0, m_ber = 0;
  logic [65:0] e_data = 66'd0;
  bit          e_vld = 0, e_slip = 0, e_lock = 0, e_hiber = 0;

  always @(posedge clk) begin
    bit ok;
    ok = (din[1:0] == 2'b01) || (din[1:0] == 2'b10);
    if (rst) begin
      m_mode = M_HUNT; m_good = 0; m_bad = 0; m_slip_left = 0;
      m_win_pos = 0; m_ber = 0;
      e_data = 66'd0; e_vld = 0; e_slip = 0; e_lock = 0; e_hiber = 0;
    end else begin
      e_vld  = vld && (m_mode == M_LOCK);
      if (vld) e_data = din;
      e_slip = 0;
      if (m_mode == M_HUNT) begin
        if (vld && ok) begin
          m_good++;
          if (m_good >= LOCK_CNT) begin m_mode = M_LOCK; m_good = 0; m_bad = 0; end
        end else if (vld) begin
          m_mode = M_SLIP; m_good = 0; m_bad = 0; m_slip_left = SLIP_WAIT; e_slip = 1;
        end
      end else if (m_mode == M_SLIP) begin
        m_slip_left--;
        if (m_slip_left == 0) begin m_mode = M_HUNT; m_good = 0; m_bad = 0; end
      end else if (vld) begin
        m_good++;
        if (!ok) m_bad++;
        if (m_bad >= BAD_LIMIT) begin
          m_mode = M_SLIP; m_good = 0; m_bad = 0; m_slip_left = SLIP_WAIT; e_slip = 1;
        end else if (m_good >= 64) begin
          m_good = 0; m_bad = 0;
        end
      end
      e_lock = (m_mode == M_LOCK);
`ifdef RX_HI_BER_MONITOR_EN
      if (vld && !ok) m_ber++;
      if (m_ber >= 16) e_hiber = 1;
      if (m_win_pos == BER_WIN - 1) begin
        if (m_ber < 16) e_hiber = 0;
        m_ber = 0; m_win_pos = 0;
      end else begin
        m_win_pos++;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("data_o", dout, e_data);
      chk("data_vld_o", {65'd0, dvld}, {65'd0, e_vld});
      chk("slip_o", {65'd0, slip}, {65'd0, e_slip});
      chk("block_lock_o", {65'd0, lock}, {65'd0, e_lock});
      chk("hi_ber_o", {65'd0, hiber}, {65'd0, e_hiber});
    end
  end

  function automatic logic [65:0] mk(input logic [1:0] hdr);
    return {$urandom(), $urandom(), hdr};
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [65:0] d);
    @(negedge clk);
    rst = r; vld = v; din = d;
  endtask

  // Outputs produced by the input most recently driven with cyc.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, mk(2'b01));
  endtask

  initial begin
    logic [65:0] last_d;
    logic [65:0] d;

    // Reset state
    do_reset();
    check_en = 1'b1;
    settle();
    chk("rst data_o", dout, 66'd0);
    chk("rst vld/slip/lock/hiber", {62'd0, dvld, slip, lock, hiber}, 66'd0);

    // Lock after exactly 64 valid headers; 65th block is the first passed
    send_good(63);
    settle();
    chk("lock after 63", {65'd0, lock}, 66'd0);
    cyc(0, 1, mk(2'b10));
    settle();
    chk("lock after 64", {65'd0, lock}, 66'd1);
    chk("64th not passed", {65'd0, dvld}, 66'd0);
    d = mk(2'b01);
    cyc(0, 1, d);
    settle();
    chk("65th passed vld", {65'd0, dvld}, 66'd1);
    chk("65th passed data", dout, d);
    last_d = d;

    // Valid toggling while locked
    for (int i = 0; i < 20; i++) begin
      d = mk(2'b01);
      cyc(0, (i % 2) == 0, d);
      settle();
      if ((i % 2) == 0) begin
        chk("toggle vld", {65'd0, dvld}, 66'd1);
        chk("toggle data", dout, d);
        last_d = d;
      end else begin
        chk("gap vld", {65'd0, dvld}, 66'd0);
        chk("gap data hold", dout, last_d);
      end
    end

    // 15 bad in a 64-window keeps lock; 16 in the next window unlocks
    do_reset();
    send_good(64);
    for (int i = 0; i < 64; i++)
      cyc(0, 1, ((i % 4) == 1 && i < 60) ? mk(2'b00) : mk(2'b01));
    settle();
    chk("15 bad keeps lock", {65'd0, lock}, 66'd1);
    for (int i = 0; i < 15; i++) cyc(0, 1, mk(2'b00));
    settle();
    chk("lock before 16th bad", {65'd0, lock}, 66'd1);
    cyc(0, 1, mk(2'b00));
    settle();
    chk("unlock on 16th bad", {65'd0, lock}, 66'd0);
    chk("slip on unlock", {65'd0, slip}, 66'd1);
    chk("unlocking block passed", {65'd0, dvld}, 66'd1);
    cyc(0, 0, 66'd0);
    settle();
    chk("slip one cycle", {65'd0, slip}, 66'd0);

    // HUNT slip: one pulse, 32 ignored cycles, then 64 more goods to lock
    do_reset();
    cyc(0, 1, mk(2'b11));
    settle();
    chk("hunt slip pulse", {65'd0, slip}, 66'd1);
    cyc(0, 1, mk(2'b01));
    settle();
    chk("hunt slip width", {65'd0, slip}, 66'd0);
    send_good(94);
    settle();
    chk("no lock at 95 goods", {65'd0, lock}, 66'd0);
    send_good(1);
    settle();
    chk("lock at 96 goods", {65'd0, lock}, 66'd1);

    // Reset in SLIP cycle 10 aborts the slip
    do_reset();
    cyc(0, 1, mk(2'b00));
    for (int i = 0; i < 9; i++) cyc(0, 1, mk(2'b11));
    cyc(1, 0, 66'd0);
    settle();
    chk("mid-slip rst outputs", {62'd0, dvld, slip, lock, hiber}, 66'd0);
    chk("mid-slip rst data", dout, 66'd0);
    cyc(0, 0, 66'd0);
    send_good(64);
    settle();
    chk("hunt after slip reset", {65'd0, lock}, 66'd1);

`ifdef RX_HI_BER_MONITOR_EN
    // 16 bad headers in one window raise hi_ber; a clean window clears it
    do_reset();
    for (int i = 0; i < 15; i++) cyc(0, 1, mk(2'b00));
    settle();
    chk("hi_ber after 15", {65'd0, hiber}, 66'd0);
    cyc(0, 1, mk(2'b11));
    settle();
    chk("hi_ber after 16", {65'd0, hiber}, 66'd1);
    for (int i = 0; i < 200; i++) cyc(0, 0, 66'd0);
    settle();
    chk("hi_ber clean window", {65'd0, hiber}, 66'd0);
`endif

    // Randomized traffic in phases of differing error density
    for (int i = 0; i < 4500; i++) begin
      int  phase;
      int  bad_div;
      bit  r, v, bad;
      phase   = (i / 500) % 3;
      bad_div = (phase == 0) ? 200 : (phase == 1) ? 8 : 3;
      r   = ($urandom_range(0, 799) == 0);
      v   = ($urandom_range(0, 9) < 8);
      bad = ($urandom_range(0, bad_div - 1) == 0);
      if (bad) d = mk(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      else     d = mk(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      cyc(r, v, d);
    end
    cyc(0, 0, 66'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_block_sync_ctrl.md
RX_BLOCK_SYNC_CTRL -- requirements
Module: rx_block_sync_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64, meaning consecutive valid sync headers required to declare lock.
REQ-002 SHALL have parameter BAD_LIMIT, default 16, meaning invalid headers within one 64-header window that force unlock.
REQ-003 SHALL have parameter SLIP_WAIT, default 32, meaning clk_i cycles held in SLIP after each slip pulse.
REQ-004 SHALL have parameter BER_WIN, default 19531, meaning hi-BER window length in clk_i cycles (125 us at 156.25 MHz).
REQ-005 SHALL have port clk_i, input, 1 bit: single clock for the whole block.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port data_i, input, 66 bits: gearbox block, [65:2] payload, [1:0] sync header.
REQ-008 SHALL have port data_vld_i, input, 1 bit: data_i valid this cycle.
REQ-009 SHALL have port data_o, output, 66 bits: data_i registered, to descrambler.
REQ-010 SHALL have port data_vld_o, output, 1 bit: block valid and aligned, to descrambler valid input.
REQ-011 SHALL have port slip_o, output, 1 bit: one-cycle pulse, gearbox shifts alignment by one bit.
REQ-012 SHALL have port block_lock_o, output, 1 bit: high while in LOCKED.
REQ-013 SHALL have port hi_ber_o, output, 1 bit: high bit-error-rate flag.

Function
REQ-014 SHALL treat a header as valid iff data_i[1:0] is 2'b01 or 2'b10, evaluated only when data_vld_i=1.
REQ-015 SHALL implement states HUNT, SLIP and LOCKED; cycles with data_vld_i=0 SHALL change no header counter.
REQ-016 HUNT: valid header increments sh_cnt; when sh_cnt reaches LOCK_CNT, go LOCKED, clear counters.
REQ-017 HUNT: invalid header clears counters, pulses slip_o for exactly the next cycle, goes SLIP.
REQ-018 SLIP SHALL ignore data_i, count SLIP_WAIT clk_i cycles from entry, then go HUNT with counters cleared.
REQ-019 LOCKED: each header increments sh_cnt, invalid ones also increment bad_cnt.
REQ-020 LOCKED: bad_cnt reaching BAD_LIMIT (with sh_cnt ≤ 64 including current) SHALL go SLIP, pulse slip_o next cycle, clear counters.
REQ-021 LOCKED: sh_cnt reaching 64 with bad_cnt below BAD_LIMIT SHALL clear both counters and stay LOCKED; if both limits hit on the same header, unlock wins.
REQ-022 block_lock_o SHALL be registered from state, rising the cycle after the LOCK_CNT-th valid header, falling the cycle after the unlocking header.
REQ-023 data_o SHALL equal data_i delayed one cycle, loaded only when data_vld_i=1, held otherwise.
REQ-024 data_vld_o SHALL be data_vld_i delayed one cycle, gated by state==LOCKED in the input cycle; the unlocking block itself is still passed.
REQ-025 Counters SHALL saturate, never wrap; sh_cnt 7 bits, bad_cnt 5 bits, slip/BER counters sized by $clog2 of parameter.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force HUNT, clear all counters, and next cycle give data_o=0, data_vld_o=0, slip_o=0, block_lock_o=0, hi_ber_o=0.
REQ-027 Reset asserted mid-SLIP or mid-LOCKED SHALL abort immediately; no slip_o pulse SHALL follow reset.

Configuration
REQ-028 With macro RX_HI_BER_MONITOR_EN defined, a free-running BER_WIN-cycle window SHALL count invalid headers (any state); reaching 16 within a window sets hi_ber_o, which clears at the end of a window with fewer than 16.
REQ-029 Without RX_HI_BER_MONITOR_EN, hi_ber_o SHALL be tied 0 and no BER counters SHALL be synthesised; other behaviour unchanged.

Verification
REQ-030 Reset, then 64 blocks header 2'b01 with data_vld_i=1 -> block_lock_o=1 on cycle after 64th, data_vld_o follows from 65th block.
REQ-031 HUNT, block with header 2'b11 -> slip_o high exactly 1 cycle, 32 cycles ignoring input, then HUNT accepts headers.
REQ-032 LOCKED, 15 headers 2'b00 within 64 -> stays locked; 16 within 64 -> block_lock_o=0, one slip_o pulse.
REQ-033 LOCKED, data_vld_i toggling 1/0 -> data_vld_o mirrors with 1-cycle latency, data_o holds during gaps.
REQ-034 Reset asserted in SLIP cycle 10 -> no slip_o, all outputs 0, HUNT on release.
REQ-035 With RX_HI_BER_MONITOR_EN, BER_WIN=100, 16 bad headers in one window -> hi_ber_o=1; next clean window -> 0.
